serial_subtractor: RTL and testbench

- Bit-serial ripple-borrow subtractor; the subtraction counterpart of the team's 4-bit ripple carry adder datapath.
- Computes a - b - bin one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop.
- Uses a start/busy/done handshake so an arithmetic controller can use it where area matters more than latency.

---
 rtl/arith_pkg.sv | 15 +
 rtl/serial_subtractor_fs.sv | 13 +
 rtl/serial_subtractor.sv | 104 ++++++++++
 tb/tb_serial_subtractor.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared FSM encodings and sizing helper for the serial arithmetic blocks
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit-counter width: enough to index WIDTH bits, never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_fs.sv
// rtl/serial_subtractor_fs.sv - combinational full-subtractor cell (x - y - br)
module fs (
  input  logic x,
  input  logic y,
  input  logic br,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ br;
  assign bo = (~x & y) | (~(x ^ y) & br);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial ripple-borrow subtractor, LSB first, start/busy/done handshake
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] diff_r;
  logic             br;
  logic             bout_r;
  logic             cell_d;
  logic             cell_bo;
  logic             last;

  assign last = (cnt == CW'(WIDTH - 1));

  fs u_fs (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .br (br),
    .d  (cell_d),
    .bo (cell_bo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Operands shift right so the cell always sees bit cnt of the latched copies.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      br     <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      diff_r <= '0;
      bout_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            br   <= bin;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sh        <= a_sh >> 1;
          b_sh        <= b_sh >> 1;
          br          <= cell_bo;
          diff_r[cnt] <= cell_d;
          if (last) begin
            bout_r <= cell_bo;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign diff = diff_r;
  assign bout = bout_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - randomized self-checking bench for serial_subtractor (WIDTH 4 and 8)
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       bin4 = 1'b0;
  logic       busy4, done4, bout4;
  logic [3:0] diff4;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       bin8 = 1'b0;
  logic       busy8, done8, bout8;
  logic [7:0] diff8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
  );

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain signed arithmetic, wrapped to w bits; borrow is a negative raw result.
  function automatic logic [32:0] ref_sub(input int w, input int x, input int y, input int bi);
    int r;
    r = x - y - bi;
    ref_sub[31:0] = 32'(r) & ((32'd1 << w) - 32'd1);
    ref_sub[32]   = (r < 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full WIDTH=4 operation with cycle-exact busy/done checks.
  task automatic op4(input logic [3:0] x, input logic [3:0] y, input logic bi, input string tag);
    logic [32:0] e;
    e = ref_sub(4, int'(x), int'(y), int'(bi));
    a4 = x; b4 = y; bin4 = bi; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    a4 = ~x; b4 = ~y; bin4 = ~bi;
    for (int i = 1; i <= 4; i++) begin
      check({tag, "_busy"}, 32'(busy4), 32'd1);
      check({tag, "_nodone"}, 32'(done4), 32'd0);
      tick();
    end
    check({tag, "_done"}, 32'(done4), 32'd1);
    check({tag, "_busy_off"}, 32'(busy4), 32'd0);
    check({tag, "_diff"}, 32'(diff4), e[31:0]);
    check({tag, "_bout"}, 32'(bout4), 32'(e[32]));
    tick();
    check({tag, "_done_off"}, 32'(done4), 32'd0);
    check({tag, "_diff_hold"}, 32'(diff4), e[31:0]);
  endtask

  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic bi);
    logic [32:0] e;
    int n;
    e = ref_sub(8, int'(x), int'(y), int'(bi));
    a8 = x; b8 = y; bin8 = bi; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    n = 1;
    while (!done8 && n < 20) begin
      tick();
      n++;
    end
    check("lat8", 32'(n), 32'd9);
    check("diff8", 32'(diff8), e[31:0]);
    check("bout8", 32'(bout8), 32'(e[32]));
    tick();
  endtask

  initial begin
    int d0, d1, ndone;

    // Reset held for three cycles
    repeat (3) tick();
    check("rst_busy", 32'(busy4), 32'd0);
    check("rst_done", 32'(done4), 32'd0);
    check("rst_diff", 32'(diff4), 32'd0);
    check("rst_bout", 32'(bout4), 32'd0);
    check("rst_busy8", 32'(busy8), 32'd0);
    rst = 1'b0;
    tick();

    op4(4'd9, 4'd3, 1'b0, "sub9_3");
    op4(4'd3, 4'd9, 1'b0, "sub3_9");
    op4(4'd0, 4'd0, 1'b1, "sub0_0_1");
    op4(4'hF, 4'hF, 1'b1, "subF_F_1");

    // Asynchronous reset between edges clears a nonzero result at once
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_diff", 32'(diff4), 32'd0);
    check("async_bout", 32'(bout4), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Start requests while busy or done are ignored
    a4 = 4'd9; b4 = 4'd3; bin4 = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 8; c++) begin
      if (done4) begin
        ndone++;
        check("ign_diff", 32'(diff4), 32'd6);
      end
      if (c == 2 || c == 5) begin
        a4 = 4'd1; b4 = 4'd1; bin4 = 1'b0; start4 = 1'b1;
      end else begin
        start4 = 1'b0;
      end
      tick();
    end
    start4 = 1'b0;
    check("ign_ndone", 32'(ndone), 32'd1);
    check("ign_diff_end", 32'(diff4), 32'd6);
    check("ign_idle", 32'(busy4), 32'd0);

    // Start held high: back-to-back operations WIDTH+2 cycles apart
    a4 = 4'd9; b4 = 4'd3; bin4 = 1'b0; start4 = 1'b1;
    tick();
    a4 = 4'd7; b4 = 4'd2;
    d0 = -1; d1 = -1;
    for (int c = 1; c <= 14; c++) begin
      if (done4) begin
        if (d0 < 0) begin
          d0 = c;
          check("held_diff1", 32'(diff4), 32'd6);
        end else begin
          d1 = c;
          check("held_diff2", 32'(diff4), 32'd5);
        end
      end
      if (c == 7) start4 = 1'b0;
      tick();
    end
    check("held_gap", 32'(d1 - d0), 32'd6);
    check("held_first", 32'(d0), 32'd5);

    // Reset mid-run aborts with no done pulse
    a4 = 4'd9; b4 = 4'd3; bin4 = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy4), 32'd0);
    check("midrst_diff", 32'(diff4), 32'd0);
    ndone = 0;
    for (int c = 0; c < 3; c++) begin
      if (done4) ndone++;
      tick();
    end
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (done4) ndone++;
      tick();
    end
    check("midrst_nodone", 32'(ndone), 32'd0);
    op4(4'd5, 4'd2, 1'b0, "after_rst");

    // WIDTH=8 corner and randomized sweep
    op8(8'h00, 8'hFF, 1'b1);
    op8(8'hFF, 8'h00, 1'b0);
    op8(8'h80, 8'h80, 1'b1);
    for (int i = 0; i < 1000; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
